// File: rtl/decode_issue_buffer_if.sv
// ----------------------------------------------------------------------------
// decode_issue_buffer_if
// Valid/ready stream carrying one instruction word and its PC.
//   valid  : producer presents a word
//   ready  : consumer accepts the word this cycle
//   instr  : instruction word, INSTR_W bits
//   pc     : address of instr, PC_W bits
// The master modport drives valid/instr/pc and samples ready; the slave
// modport does the opposite.
// ----------------------------------------------------------------------------
interface decode_issue_buffer_if #(
  parameter int INSTR_W = 33,
  parameter int PC_W    = 16
);
  logic               valid;
  logic               ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;

  modport master (
    output valid,
    output instr,
    output pc,
    input  ready
  );

  modport slave (
    input  valid,
    input  instr,
    input  pc,
    output ready
  );
endinterface

// File: rtl/decode_issue_buffer.sv
// ----------------------------------------------------------------------------
// decode_issue_buffer
// Two-entry skid buffer between instruction fetch and the control decoder.
// Words enter over in_if, leave over id_if in strict FIFO order, and the head
// entry stays stable while decode stalls. A taken branch/jump flush empties
// the buffer; consuming a head that the decoder flags as halting latches a
// sticky halt that stops all further intake until rst_n.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_if        : fetch side stream (slave); ready = !full && !halted
//   id_if        : decode side stream (master); head entry of the buffer
//   id_dec_field : id_instr[32:26] for the decoder (opcode 26..30, func 31..32)
//   dec_halt     : decoder halt flag for the current head
//   flush        : synchronous redirect, highest priority
//   halted       : sticky halt status
//   perf_fire    : words issued to decode (saturating)
//   perf_stall   : cycles with id_valid && !id_ready (saturating)
//
// Build option
//   DIB_PERF_CNT_EN : when defined, the two performance counters are built;
//                     otherwise perf_fire/perf_stall are tied to zero.
// ----------------------------------------------------------------------------
module decode_issue_buffer #(
  parameter int INSTR_W = 33,
  parameter int PC_W    = 16,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  decode_issue_buffer_if.slave    in_if,
  decode_issue_buffer_if.master   id_if,
  output logic [6:0]              id_dec_field,
  input  logic                    dec_halt,
  input  logic                    flush,
  output logic                    halted,
  output logic [CNT_W-1:0]        perf_fire,
  output logic [CNT_W-1:0]        perf_stall
);

  // Storage: two slots addressed by a 1-bit read pointer; the write slot is
  // the read pointer advanced by the current occupancy.
  logic [INSTR_W-1:0] instr_q [2];
  logic [INSTR_W-1:0] instr_d [2];
  logic [PC_W-1:0]    pc_q    [2];
  logic [PC_W-1:0]    pc_d    [2];
  logic [1:0]         count_q, count_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               halted_q, halted_d;

  logic               wr_ptr;
  logic               push;
  logic               pop;
  logic               halt_set;
  logic               in_ready_int;
  logic               id_valid_int;

  // Handshake terms depend only on registered state, so in_ready never
  // follows id_ready combinationally and a full buffer cannot accept even
  // when the head is popped in the same cycle.
  assign in_ready_int = (count_q != 2'd2) && !halted_q;
  assign id_valid_int = (count_q != 2'd0);
  assign push         = in_if.valid && in_ready_int;
  assign pop          = id_valid_int && id_if.ready;
  assign halt_set     = pop && dec_halt;

  // Next-state computation for occupancy, pointer, slot contents and halt.
  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    halted_d = halted_q;
    wr_ptr   = rd_ptr_q ^ count_q[0];

    // A word offered during flush is dropped, so it is never written.
    if (push && !flush) begin
      instr_d[wr_ptr] = in_if.instr;
      pc_d[wr_ptr]    = in_if.pc;
    end else begin
      instr_d = instr_q;
      pc_d    = pc_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Halt is recorded even when a flush arrives in the same cycle: the
    // halting word was still consumed.
    if (halt_set) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end

    if (flush || halt_set) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q[0] <= {INSTR_W{1'b0}};
      instr_q[1] <= {INSTR_W{1'b0}};
      pc_q[0]    <= {PC_W{1'b0}};
      pc_q[1]    <= {PC_W{1'b0}};
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      halted_q   <= halted_d;
    end
  end

  assign in_if.ready  = in_ready_int;
  assign id_if.valid  = id_valid_int;
  assign id_if.instr  = instr_q[rd_ptr_q];
  assign id_if.pc     = pc_q[rd_ptr_q];
  assign id_dec_field = instr_q[rd_ptr_q][32:26];
  assign halted       = halted_q;

`ifdef DIB_PERF_CNT_EN
  logic [CNT_W-1:0] fire_q,  fire_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating event counters; flush leaves them untouched.
  always_comb begin
    fire_d  = fire_q;
    stall_d = stall_q;
    if (pop && (fire_q != {CNT_W{1'b1}})) begin
      fire_d = fire_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      fire_d = fire_q;
    end
    if (id_valid_int && !id_if.ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // Performance counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_q  <= {CNT_W{1'b0}};
      stall_q <= {CNT_W{1'b0}};
    end else begin
      fire_q  <= fire_d;
      stall_q <= stall_d;
    end
  end

  assign perf_fire  = fire_q;
  assign perf_stall = stall_q;
`else
  assign perf_fire  = {CNT_W{1'b0}};
  assign perf_stall = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_decode_issue_buffer.sv
// ----------------------------------------------------------------------------
// tb_decode_issue_buffer
// Directed scenarios followed by a randomized run, all compared against a
// queue-based model of the buffer's transfer rules.
// ----------------------------------------------------------------------------
module tb_decode_issue_buffer;

  localparam int INSTR_W = 33;
  localparam int PC_W    = 16;
  localparam int CNT_W   = 16;

  logic              clk;
  logic              rst_n;
  logic [6:0]        id_dec_field;
  logic              dec_halt;
  logic              flush;
  logic              halted;
  logic [CNT_W-1:0]  perf_fire;
  logic [CNT_W-1:0]  perf_stall;

  decode_issue_buffer_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) fe_if ();
  decode_issue_buffer_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) id_if ();

  decode_issue_buffer #(.INSTR_W(INSTR_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (fe_if),
    .id_if        (id_if),
    .id_dec_field (id_dec_field),
    .dec_halt     (dec_halt),
    .flush        (flush),
    .halted       (halted),
    .perf_fire    (perf_fire),
    .perf_stall   (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ent_t;

  ent_t mq[$];
  bit   m_halted;
  int   m_fire;
  int   m_stall;
  int   total;
  int   bad;
  bit   last_accept;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model (called away from the clock edge).
  task automatic compare_all();
    logic [INSTR_W-1:0] hi;
    chk("in_ready", 64'(fe_if.ready), 64'((mq.size() < 2) && !m_halted));
    chk("id_valid", 64'(id_if.valid), 64'(mq.size() > 0));
    chk("halted",   64'(halted),      64'(m_halted));
    if (mq.size() > 0) begin
      hi = mq[0].instr;
      chk("id_instr",     64'(id_if.instr),  64'(hi));
      chk("id_pc",        64'(id_if.pc),     64'(mq[0].pc));
      chk("id_dec_field", 64'(id_dec_field), 64'(hi[32:26]));
    end
`ifdef DIB_PERF_CNT_EN
    chk("perf_fire",  64'(perf_fire),  64'(m_fire));
    chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`else
    chk("perf_fire",  64'(perf_fire),  64'd0);
    chk("perf_stall", 64'(perf_stall), 64'd0);
`endif
  endtask

  // One clock cycle: drive, check, advance the model across the edge.
  task automatic step(input bit iv, input logic [INSTR_W-1:0] ins, input logic [PC_W-1:0] pc,
                      input bit ir, input bit dh, input bit fl);
    bit   rdy, acc, pp;
    ent_t e;
    fe_if.valid = iv;
    fe_if.instr = ins;
    fe_if.pc    = pc;
    id_if.ready = ir;
    dec_halt    = dh;
    flush       = fl;
    #1;
    compare_all();
    rdy = (mq.size() < 2) && !m_halted;
    acc = iv && rdy;
    pp  = (mq.size() > 0) && ir;
    if (pp && m_fire < 65535) m_fire++;
    if ((mq.size() > 0) && !ir && m_stall < 65535) m_stall++;
    if (pp && dh) m_halted = 1'b1;
    if (fl || (pp && dh)) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        e.instr = ins;
        e.pc    = pc;
        mq.push_back(e);
      end
    end
    last_accept = acc && !fl;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    fe_if.valid = 1'b0;
    fe_if.instr = '0;
    fe_if.pc    = '0;
    id_if.ready = 1'b0;
    dec_halt    = 1'b0;
    flush       = 1'b0;
    mq.delete();
    m_halted = 1'b0;
    m_fire   = 0;
    m_stall  = 0;
    #1;
    chk("rst_id_valid", 64'(id_if.valid), 64'd0);
    chk("rst_id_instr", 64'(id_if.instr), 64'd0);
    chk("rst_id_pc",    64'(id_if.pc),    64'd0);
    chk("rst_in_ready", 64'(fe_if.ready), 64'd1);
    chk("rst_halted",   64'(halted),      64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [INSTR_W-1:0] rnd_instr();
    return {1'($urandom), 32'($urandom)};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    last_accept = 1'b0;

    // T1: single word, one-cycle latency, decoder slice.
    do_reset();
    step(1'b1, 33'h0_0400_0010, 16'h0004, 1'b1, 1'b0, 1'b0);
    chk("t1_dec_field", 64'(id_dec_field), 64'h01);
    chk("t1_pc",        64'(id_if.pc),     64'h0004);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // T2: three words against a stalled decoder, then drain in order.
    step(1'b1, 33'h1_AAAA_0001, 16'h0100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 33'h0_BBBB_0002, 16'h0104, 1'b0, 1'b0, 1'b0);
    chk("t2_full_ready", 64'(fe_if.ready), 64'd0);
    step(1'b1, 33'h1_CCCC_0003, 16'h0108, 1'b0, 1'b0, 1'b0);
    chk("t2_head_a", 64'(id_if.pc), 64'h0100);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 33'h1_CCCC_0003, 16'h0108, 1'b1, 1'b0, 1'b0);
      if (last_accept) break;
    end
    chk("t2_c_accepted", 64'(last_accept), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // T3: steady one-in/one-out at occupancy 1.
    step(1'b1, 33'h0_0000_1000, 16'h0200, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 33'(i + 'h2000), 16'(16'h0210 + 16'(i)), 1'b1, 1'b0, 1'b0);
      chk("t3_valid", 64'(id_if.valid), 64'd1);
    end
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // T4: flush while full with a word offered.
    step(1'b1, 33'h0_4444_0001, 16'h0300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 33'h0_4444_0002, 16'h0304, 1'b0, 1'b0, 1'b0);
    step(1'b1, 33'h0_4444_0003, 16'h0308, 1'b0, 1'b0, 1'b1);
    chk("t4_valid", 64'(id_if.valid), 64'd0);
    chk("t4_ready", 64'(fe_if.ready), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // T5: halting head consumed with a second entry pending.
    step(1'b1, 33'h0_5555_0001, 16'h0400, 1'b0, 1'b0, 1'b0);
    step(1'b1, 33'h0_5555_0002, 16'h0404, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("t5_halted", 64'(halted),      64'd1);
    chk("t5_valid",  64'(id_if.valid), 64'd0);
    chk("t5_ready",  64'(fe_if.ready), 64'd0);
    step(1'b1, 33'h0_5555_0003, 16'h0408, 1'b1, 1'b0, 1'b1);
    chk("t5_flush_keeps_halt", 64'(halted), 64'd1);
    step(1'b1, 33'h0_5555_0004, 16'h040C, 1'b1, 1'b0, 1'b0);
    do_reset();
    chk("t5_reset_clears_halt", 64'(halted), 64'd0);

    // T6-style counter activity: 3 stall cycles then 5 pops.
    step(1'b1, 33'h0_6666_0001, 16'h0500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 33'h0_6666_0002, 16'h0504, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 33'(i + 'h6000), 16'(16'h0510 + 16'(i)), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flush and halt.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halted && ($urandom_range(3, 0) == 0)) begin
        do_reset();
      end else begin
        step(1'($urandom_range(3, 0) != 0), rnd_instr(), 16'($urandom),
             1'($urandom_range(2, 0) != 0),
             1'($urandom_range(29, 0) == 0),
             1'($urandom_range(14, 0) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
